// File: rtl/spi_aes_host.sv
// rtl/spi_aes_host.sv - host serializer/deserializer for bit-serial AES encrypt/decrypt slaves
//
// Purpose: accepts a 128-bit block, a key and a mode bit over start/busy/done,
// shifts the block then the key LSB-first onto the shared serial line, idles for
// the slave's fixed latency, then captures the 128-bit result LSB-first from the
// selected slave's serial output.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous active-low reset
//   start                request pulse, accepted only in IDLE
//   mode                 0 = encrypt slave, 1 = decrypt slave (latched on start)
//   data_in[127:0]       input block
//   key_in[KEY_BITS-1:0] key
//   busy                 high from accepted start until done
//   done                 one-cycle result-valid pulse
//   result[127:0]        captured block, held until overwritten by the next capture
//   in                   serial line to both slaves
//   out_enc / out_dec    serial outputs of the slaves
//   enable_enc/_dec      slave enables
//   chip_enc/_dec        active-low slave selects
//
// Optional feature (macro SPI_AES_HOST_CHECK_EN):
//   expected[127:0]      reference block latched on start
//   mismatch             result != expected, valid from the done cycle, held until next start
//
// LATENCY must be at least 1.

module spi_aes_host #(
  parameter int KEY_BITS = 128,
  parameter int LATENCY  = 20,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [127:0]        data_in,
  input  logic [KEY_BITS-1:0] key_in,
`ifdef SPI_AES_HOST_CHECK_EN
  input  logic [127:0]        expected,
  output logic                mismatch,
`endif
  output logic                busy,
  output logic                done,
  output logic [127:0]        result,
  output logic                in,
  input  logic                out_enc,
  input  logic                out_dec,
  output logic                enable_enc,
  output logic                enable_dec,
  output logic                chip_enc,
  output logic                chip_dec
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_DATA,
    SEND_KEY,
    WAIT_LAT,
    RECV,
    DONE_ST
  } state_t;

  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(127);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY - 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [127:0]        data_sr;
  logic [KEY_BITS-1:0] key_sr;
  logic                mode_q;
  logic [127:0]        result_q;
  logic                accept;
  logic                active;
  logic                serial_out;

  assign accept     = (state == IDLE) && start;
  assign serial_out = mode_q ? out_dec : out_enc;
  assign result     = result_q;

  // State and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state; the counter restarts from 0 on every state entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = SEND_DATA;
      end
      SEND_DATA: begin
        if (cnt == BLK_LAST) begin
          state_n = SEND_KEY;
          cnt_n   = '0;
        end
      end
      SEND_KEY: begin
        if (cnt == KEY_LAST) begin
          state_n = WAIT_LAT;
          cnt_n   = '0;
        end
      end
      WAIT_LAT: begin
        if (cnt == LAT_LAST) begin
          state_n = RECV;
          cnt_n   = '0;
        end
      end
      RECV: begin
        if (cnt == BLK_LAST) begin
          state_n = DONE_ST;
          cnt_n   = '0;
        end
      end
      DONE_ST: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state; the slave select covers the
  // whole transfer from the first data bit to the last capture edge.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    in         = 1'b0;
    active     = 1'b0;
    enable_enc = 1'b0;
    enable_dec = 1'b0;
    chip_enc   = 1'b1;
    chip_dec   = 1'b1;
    case (state)
      SEND_DATA: begin
        busy   = 1'b1;
        active = 1'b1;
        in     = data_sr[0];
      end
      SEND_KEY: begin
        busy   = 1'b1;
        active = 1'b1;
        in     = key_sr[0];
      end
      WAIT_LAT, RECV: begin
        busy   = 1'b1;
        active = 1'b1;
      end
      DONE_ST: done = 1'b1;
      default: ;
    endcase
    if (active) begin
      if (mode_q) begin
        enable_dec = 1'b1;
        chip_dec   = 1'b0;
      end else begin
        enable_enc = 1'b1;
        chip_enc   = 1'b0;
      end
    end
  end

  // Operand latches and shift registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_sr <= '0;
      key_sr  <= '0;
      mode_q  <= 1'b0;
    end else if (accept) begin
      data_sr <= data_in;
      key_sr  <= key_in;
      mode_q  <= mode;
    end else if (state == SEND_DATA) begin
      data_sr <= {1'b0, data_sr[127:1]};
    end else if (state == SEND_KEY) begin
      key_sr <= {1'b0, key_sr[KEY_BITS-1:1]};
    end
  end

  // Result capture: bit j lands on the j-th rising edge spent in RECV.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else if (state == RECV) begin
      result_q[cnt[6:0]] <= serial_out;
    end
  end

`ifdef SPI_AES_HOST_CHECK_EN
  logic [127:0] expected_q;
  logic         mismatch_q;
  logic         mismatch_now;

  assign mismatch_now = (result_q != expected_q);
  assign mismatch     = (state == DONE_ST) ? mismatch_now : mismatch_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected_q <= '0;
      mismatch_q <= 1'b0;
    end else if (accept) begin
      expected_q <= expected;
      mismatch_q <= 1'b0;
    end else if (state == DONE_ST) begin
      mismatch_q <= mismatch_now;
    end
  end
`endif

endmodule

// File: tb/tb_spi_aes_host.sv
// tb/tb_spi_aes_host.sv - self-checking bench for spi_aes_host with behavioural serial slaves

module tb_spi_aes_host;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int           LAT = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         busy, done, in_line;
  logic [127:0] result;
  logic         out_enc = 1'b0;
  logic         out_dec = 1'b0;
  logic         enable_enc, enable_dec, chip_enc, chip_dec;
`ifdef SPI_AES_HOST_CHECK_EN
  logic [127:0] expected = '0;
  logic         mismatch;
`endif

  int vectors = 0;
  int miscompares = 0;

  spi_aes_host dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .data_in    (data_in),
    .key_in     (key_in),
`ifdef SPI_AES_HOST_CHECK_EN
    .expected   (expected),
    .mismatch   (mismatch),
`endif
    .busy       (busy),
    .done       (done),
    .result     (result),
    .in         (in_line),
    .out_enc    (out_enc),
    .out_dec    (out_dec),
    .enable_enc (enable_enc),
    .enable_dec (enable_dec),
    .chip_enc   (chip_enc),
    .chip_dec   (chip_dec)
  );

  always #5 clk = ~clk;

  // Stand-in for the AES cores: the known test vector maps to the real AES
  // answer, anything else to a simple keyed scramble distinct per direction.
  function automatic logic [127:0] slave_fn(input logic m, input logic [127:0] d, input logic [127:0] k);
    if (!m && d == PT && k == KEY) return CT;
    if (m && d == CT && k == KEY) return PT;
    if (!m) return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    return ~d ^ k;
  endfunction

  // Behavioural slaves: collect 256 bits (block then key) on enabled edges,
  // stay silent LAT cycles, then present result bits LSB-first.
  int           enc_n = 0, dec_n = 0;
  logic [255:0] enc_rx, dec_rx;
  logic [127:0] enc_res, dec_res;

  always @(posedge clk) begin
    if (enable_enc && !chip_enc) begin
      enc_n = enc_n + 1;
      if (enc_n <= 256) enc_rx[enc_n-1] = in_line;
      if (enc_n == 256) enc_res = slave_fn(1'b0, enc_rx[127:0], enc_rx[255:128]);
      if (enc_n >= 256 + LAT && enc_n < 256 + LAT + 128) out_enc <= enc_res[enc_n-256-LAT];
    end else begin
      enc_n = 0;
    end
  end

  always @(posedge clk) begin
    if (enable_dec && !chip_dec) begin
      dec_n = dec_n + 1;
      if (dec_n <= 256) dec_rx[dec_n-1] = in_line;
      if (dec_n == 256) dec_res = slave_fn(1'b1, dec_rx[127:0], dec_rx[255:128]);
      if (dec_n >= 256 + LAT && dec_n < 256 + LAT + 128) out_dec <= dec_res[dec_n-256-LAT];
    end else begin
      dec_n = 0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {127'd0, busy}, 128'd0);
    check({tag, "_done"}, {127'd0, done}, 128'd0);
    check({tag, "_result"}, result, 128'd0);
    check({tag, "_in"}, {127'd0, in_line}, 128'd0);
    check({tag, "_en"}, {126'd0, enable_enc, enable_dec}, 128'd0);
    check({tag, "_chip"}, {126'd0, chip_enc, chip_dec}, 128'd3);
`ifdef SPI_AES_HOST_CHECK_EN
    check({tag, "_mismatch"}, {127'd0, mismatch}, 128'd0);
`endif
  endtask

  // One transaction from start to the idle cycle after done. abort_at > 0
  // pulls reset during that cycle instead of completing.
  task automatic run_txn(input string name, input logic m, input logic [127:0] d, input logic [127:0] k,
                         input logic [127:0] exp_res, input logic [127:0] exp_port, input logic exp_mm,
                         input int abort_at, input bit busy_start, input bit done_start);
    int in_err = 0, unsel_err = 0, sel_err = 0, busy_err = 0, dones = 0;
    logic [127:0] prev;
    prev = result;
    @(negedge clk);
    start = 1'b1; mode = m; data_in = d; key_in = k;
`ifdef SPI_AES_HOST_CHECK_EN
    expected = exp_port;
`endif
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    key_in  = {$urandom, $urandom, $urandom, $urandom};
`ifdef SPI_AES_HOST_CHECK_EN
    expected = ~exp_port;
`endif
    for (int c = 1; c <= 405; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        check_reset_outputs({name, "_abort"});
        @(negedge clk);
        check({name, "_abort_nodone"}, {127'd0, done}, 128'd0);
        reset = 1'b1;
        return;
      end
      if (c == 1) check({name, "_result_held"}, result, prev);
      if (c <= 128) begin
        if (in_line !== d[c-1]) in_err++;
      end else if (c <= 256) begin
        if (in_line !== k[c-129]) in_err++;
      end else if (in_line !== 1'b0) begin
        in_err++;
      end
      if (m) begin
        if (chip_enc !== 1'b1 || enable_enc !== 1'b0) unsel_err++;
        if ((c <= 404) !== (enable_dec === 1'b1 && chip_dec === 1'b0)) sel_err++;
      end else begin
        if (chip_dec !== 1'b1 || enable_dec !== 1'b0) unsel_err++;
        if ((c <= 404) !== (enable_enc === 1'b1 && chip_enc === 1'b0)) sel_err++;
      end
      if (busy !== (c <= 404)) busy_err++;
      if (done === 1'b1) dones++;
      if (c == 405) check({name, "_done_at_405"}, {127'd0, done}, 128'd1);
      if (busy_start && c == 50) begin
        start = 1'b1; mode = ~m;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        key_in  = ~k;
      end
      if (busy_start && c == 51) start = 1'b0;
      if (done_start && c == 405) start = 1'b1;
    end
    check({name, "_result"}, result, exp_res);
`ifdef SPI_AES_HOST_CHECK_EN
    check({name, "_mismatch_done"}, {127'd0, mismatch}, {127'd0, exp_mm});
`endif
    @(negedge clk);
    start = 1'b0;
    check({name, "_idle_after"}, {126'd0, busy, done}, 128'd0);
    check({name, "_framing_errs"}, 128'(in_err), 128'd0);
    check({name, "_unselected_errs"}, 128'(unsel_err), 128'd0);
    check({name, "_selected_errs"}, 128'(sel_err), 128'd0);
    check({name, "_busy_errs"}, 128'(busy_err), 128'd0);
    check({name, "_done_pulses"}, 128'(dones), 128'd1);
    check({name, "_result_hold"}, result, exp_res);
`ifdef SPI_AES_HOST_CHECK_EN
    check({name, "_mismatch_hold"}, {127'd0, mismatch}, {127'd0, exp_mm});
`endif
  endtask

  logic [127:0] rd, rk;
  logic         rm;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    run_txn("enc_known", 1'b0, PT, KEY, CT, CT, 1'b0, 0, 1'b0, 1'b0);
    run_txn("dec_known", 1'b1, CT, KEY, PT, PT, 1'b0, 0, 1'b0, 1'b0);
    run_txn("enc_busy_start", 1'b0, PT, KEY, CT, CT, 1'b0, 0, 1'b1, 1'b0);
    run_txn("enc_check_bad", 1'b0, PT, KEY, CT, 128'd0, 1'b1, 0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      run_txn($sformatf("rand%0d", i), rm, rd, rk, slave_fn(rm, rd, rk), slave_fn(rm, rd, rk),
              1'b0, 0, (i == 1), (i == 2));
    end

    rd = {$urandom, $urandom, $urandom, $urandom};
    run_txn("abort", 1'b1, rd, KEY, 128'd0, 128'd0, 1'b0, 200, 1'b0, 1'b0);
    @(negedge clk);
    check_reset_outputs("after_abort");
    run_txn("after_abort_enc", 1'b0, PT, KEY, CT, CT, 1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
